mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
Parametrised successor to the fixed instruction/data request path. Arbitrates NUM_PORTS independent memory requestors (fetch, load/store, debug, DMA) onto one single-ported RAM interface that signals completion via busy. Round-robin arbitration, latched request capture, per-port one-cycle ready/error response, and a bus-hang timeout. Sits between the pipeline request logic and the RAM.

Parameters:
NUM_PORTS, 2, number of requestor ports (>=1); port 0 = lowest index
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYC, 16, max cycles in ISSUE with ram_busy high before abort; 0 = timeout disabled
CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2**CNT_W

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
req_ren  in  NUM_PORTS  per-port read request, level, held until ready/err
req_wen  in  NUM_PORTS  per-port write request, level, held until ready/err
req_addr  in  NUM_PORTS*ADDR_W  packed addresses, port p at [p*ADDR_W +: ADDR_W]
req_wdata  in  NUM_PORTS*DATA_W  packed write data, same packing
req_rdata  out  NUM_PORTS*DATA_W  packed read data, valid only with req_ready[p]
req_ready  out  NUM_PORTS  one-cycle completion pulse per port
req_err  out  NUM_PORTS  one-cycle timeout-abort pulse per port
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid when ram_busy low during access
ram_busy  in  1  RAM busy; access completes in first ISSUE cycle with ram_busy=0

Behaviour:
- Reset (RST=1 at clock edge): state IDLE, rr_ptr=0, tcnt=0; all outputs 0. Reset in any state aborts the access immediately; no ready/err issued for it.
- Port p requesting = req_ren[p] | req_wen[p]. Both set: treated as write.
- States: IDLE, ISSUE, RESP.
- IDLE: if any port requesting, grant g = first requesting port searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS; latch g, op, addr, wdata; -> ISSUE. Else stay.
- ISSUE: ram_ren/ram_wen = latched op, ram_addr/ram_wdata = latched values (registered, stable whole state). tcnt increments each cycle ram_busy=1.
  - ram_busy=0: capture ram_rdata (reads; writes capture 0) -> RESP, ok.
  - ram_busy=1 and tcnt==TIMEOUT_CYC-1 (TIMEOUT_CYC>0): -> RESP, abort.
- RESP (1 cycle): ram strobes 0; ok: req_ready[g]=1, req_rdata slice g = captured data; abort: req_err[g]=1, slice g = 0. Other slices always 0. rr_ptr = (g+1) mod NUM_PORTS; tcnt=0; -> IDLE.
- Min latency: request seen in IDLE cycle t, ISSUE t+1 (busy low), ready at t+2. Back-to-back grants: one IDLE cycle between accesses.
- Requester deasserting mid-access: access still completes, ready/err still pulses. Request changes after latch ignored.
- Requester must drop or replace its request the cycle after ready/err; still asserted in IDLE = new request.
- ready and err never both high; at most one port pulses per cycle.
- NUM_PORTS=1: arbitration degenerates, rr_ptr stays 0.

Optional Feature:
Macro ARB_FIXED_PRIO_EN. Defined: round-robin replaced by fixed priority, highest-index requesting port always wins (data/debug above fetch); rr_ptr not implemented. Undefined: round-robin as above.

Test Plan:
- Single read: port0 ren, addr 0x100, ram_busy high 2 cycles then low with ram_rdata 0xDEADBEEF -> ram_ren=1, ram_addr=0x100 for 3 ISSUE cycles; req_ready[0] one pulse, rdata slice0 0xDEADBEEF, latency 4 cycles.
- Write: port1 wen, addr 0x20, wdata 0x1234, busy low -> ram_wen=1 one cycle with 0x20/0x1234; req_ready[1] at t+2; ram_ren stays 0.
- Contention: ports 0 and 1 request continuously, busy 0 -> grants alternate 0,1,0,1 from reset; with ARB_FIXED_PRIO_EN port1 always granted.
- Timeout: TIMEOUT_CYC=16, port0 read, ram_busy stuck high -> req_err[0] pulses exactly once after 16 ISSUE cycles, req_ready never high, strobes drop in RESP.
- Reset mid-access: RST asserted during ISSUE -> next cycle all outputs 0, state IDLE, no ready/err; port1 request after reset granted first (rr_ptr=0 search finds port1 if port0 idle).
- Request withdrawn: port0 ren dropped during ISSUE -> access completes, req_ready[0] still pulses once.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of NUM_PORTS memory requestors onto one busy-handshaked RAM port.
// Define ARB_FIXED_PRIO_EN for fixed priority (highest index wins) instead of round-robin.
module mem_req_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_PORTS-1:0]        req_ren,
  input  logic [NUM_PORTS-1:0]        req_wen,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS*DATA_W-1:0] req_rdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        req_err,
  output logic                        ram_ren,
  output logic                        ram_wen,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  input  logic                        ram_busy
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     gnt_q;
  logic [PTR_W-1:0]     gnt_d;
  logic                 any_req_d;
  logic [CNT_W-1:0]     tcnt_q;
  logic [NUM_PORTS-1:0] req_any;

  assign req_any = req_ren | req_wen;

`ifdef ARB_FIXED_PRIO_EN
  // Ascending scan: the last hit, i.e. the highest requesting index, wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    gnt_d     = '0;
    any_req_d = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_any[i]) begin
        gnt_d     = PTR_W'(i);
        any_req_d = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q;

  // Descending scan of offsets from rr_ptr: the smallest offset is written last and wins.
  always_comb begin
    int idx;
    gnt_d     = '0;
    any_req_d = 1'b0;
    idx       = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req_any[idx]) begin
        gnt_d     = PTR_W'(idx);
        any_req_d = 1'b1;
      end
    end
  end
`endif

  // NOTE: all state and outputs here are registers, so only non-blocking assignments are used.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      tcnt_q    <= '0;
      req_rdata <= '0;
      req_ready <= '0;
      req_err   <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      req_ready <= '0;
      req_err   <= '0;
      req_rdata <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            gnt_q     <= gnt_d;
            ram_wen   <= req_wen[gnt_d];
            ram_ren   <= ~req_wen[gnt_d];
            ram_addr  <= req_addr[gnt_d*ADDR_W +: ADDR_W];
            ram_wdata <= req_wdata[gnt_d*DATA_W +: DATA_W];
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!ram_busy) begin
            req_ready[gnt_q]                 <= 1'b1;
            req_rdata[gnt_q*DATA_W +: DATA_W] <= ram_wen ? '0 : ram_rdata;
            ram_ren                          <= 1'b0;
            ram_wen                          <= 1'b0;
            state_q                          <= S_RESP;
          end else if ((TIMEOUT_CYC > 0) && (tcnt_q == TMO_LAST)) begin
            req_err[gnt_q] <= 1'b1;
            ram_ren        <= 1'b0;
            ram_wen        <= 1'b0;
            state_q        <= S_RESP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          tcnt_q  <= '0;
          state_q <= S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
          if (int'(gnt_q) == NUM_PORTS - 1) rr_ptr_q <= '0;
          else                              rr_ptr_q <= gnt_q + 1'b1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter in its default round-robin build, 2 ports, TIMEOUT_CYC=16.
module tb_mem_req_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] W0 = 32'h0000_A0A0;
  localparam logic [31:0] W1 = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_ren, req_wen;
  logic [63:0] req_addr, req_wdata, req_rdata;
  logic [1:0]  req_ready, req_err;
  logic        ram_ren, ram_wen, ram_busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  mem_req_arbiter #(
    .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16), .CNT_W(8)
  ) dut (
    .CLK(clk), .RST(rst),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_ready(req_ready), .req_err(req_err),
    .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ren, wen;
    logic        busy;
    logic [31:0] rdi;
    logic [1:0]  e_ready, e_err;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [1:0] ren, logic [1:0] wen, logic busy, logic [31:0] rdi,
                              logic [1:0] e_ready, logic e_ren, logic e_wen,
                              logic [31:0] e_addr, logic [31:0] e_wdata, logic [63:0] e_rdata);
    vec_t v;
    v.ren = ren; v.wen = wen; v.busy = busy; v.rdi = rdi;
    v.e_ready = e_ready; v.e_err = 2'b00; v.e_ren = e_ren; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, issue_cnt, ready_cnt, err_at, lat;
    logic seen_ready, ren_at_err;

    rst = 1'b1; req_ren = '0; req_wen = '0; ram_busy = 1'b0; ram_rdata = '0;
    req_addr = {A1, A0}; req_wdata = {W1, W0};
    step(); step();
    check("reset_outputs",
          {req_rdata, req_ready, req_err, ram_ren, ram_wen, ram_addr, ram_wdata} & 64'hFFFF_FFFF_FFFF_FFFF,
          64'h0);
    check("reset_ram_bus", {ram_ren, ram_wen, ram_addr, ram_wdata, req_ready, req_err}, 64'h0);
    rst = 1'b0;

    // Write on port1, round-robin contention, held request, and ren+wen treated as write.
    tbl.push_back(mk(2'b00, 2'b10, 1'b0, 32'h0,        2'b00, 1'b0, 1'b1, A1, W1, 64'h0));
    tbl.push_back(mk(2'b00, 2'b10, 1'b0, 32'h0,        2'b10, 1'b0, 1'b0, '0, '0, 64'h0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, '0, '0, 64'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, A0, '0, 64'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h1111_1111, 2'b01, 1'b0, 1'b0, '0, '0, {32'h0, 32'h1111_1111}));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, '0, '0, 64'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, A1, '0, 64'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h2222_2222, 2'b10, 1'b0, 1'b0, '0, '0, {32'h2222_2222, 32'h0}));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, '0, '0, 64'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, A0, '0, 64'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 32'h3333_3333, 2'b01, 1'b0, 1'b0, '0, '0, {32'h0, 32'h3333_3333}));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, '0, '0, 64'h0));
    tbl.push_back(mk(2'b01, 2'b01, 1'b0, 32'h0,        2'b00, 1'b0, 1'b1, A0, W0, 64'h0));
    tbl.push_back(mk(2'b01, 2'b01, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b1, A0, W0, 64'h0));
    tbl.push_back(mk(2'b01, 2'b01, 1'b0, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, '0, '0, 64'h0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, '0, '0, 64'h0));

    foreach (tbl[i]) begin
      req_ren = tbl[i].ren; req_wen = tbl[i].wen;
      ram_busy = tbl[i].busy; ram_rdata = tbl[i].rdi;
      step();
      check($sformatf("v%0d ready", i), {62'h0, req_ready}, {62'h0, tbl[i].e_ready});
      check($sformatf("v%0d err", i), {62'h0, req_err}, {62'h0, tbl[i].e_err});
      check($sformatf("v%0d strobes", i), {62'h0, ram_ren, ram_wen}, {62'h0, tbl[i].e_ren, tbl[i].e_wen});
      check($sformatf("v%0d rdata", i), req_rdata, tbl[i].e_rdata);
      if (tbl[i].e_ren || tbl[i].e_wen)
        check($sformatf("v%0d addr", i), {32'h0, ram_addr}, {32'h0, tbl[i].e_addr});
      if (tbl[i].e_wen)
        check($sformatf("v%0d wdata", i), {32'h0, ram_wdata}, {32'h0, tbl[i].e_wdata});
    end

    // Single read: busy high for two ISSUE cycles, low on the third.
    req_ren = 2'b01; req_wen = '0; ram_busy = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    issue_cnt = 0; lat = 0;
    for (n = 1; n <= 20; n++) begin
      ram_busy = (n >= 4) ? 1'b0 : 1'b1;
      step();
      if (ram_ren) begin
        issue_cnt++;
        check("read_addr", {32'h0, ram_addr}, {32'h0, A0});
      end
      if (req_ready != 2'b00) begin lat = n; break; end
    end
    check("read_latency", 64'(lat), 64'd4);
    check("read_issue_cycles", 64'(issue_cnt), 64'd3);
    check("read_ready", {62'h0, req_ready}, 64'h1);
    check("read_rdata", req_rdata, {32'h0, 32'hDEAD_BEEF});
    req_ren = '0;
    step();
    check("read_ready_pulse", {62'h0, req_ready}, 64'h0);

    // Timeout: busy stuck high.
    req_ren = 2'b01; ram_busy = 1'b1;
    issue_cnt = 0; err_at = 0; seen_ready = 1'b0; ren_at_err = 1'b1;
    for (n = 1; n <= 40; n++) begin
      step();
      if (ram_ren) issue_cnt++;
      if (req_ready != 2'b00) seen_ready = 1'b1;
      if (req_err != 2'b00) begin
        err_at = n; ren_at_err = ram_ren;
        check("tmo_err_port", {62'h0, req_err}, 64'h1);
        check("tmo_rdata_zero", req_rdata, 64'h0);
        break;
      end
    end
    check("tmo_err_cycle", 64'(err_at), 64'd17);
    check("tmo_issue_cycles", 64'(issue_cnt), 64'd16);
    check("tmo_no_ready", {63'h0, seen_ready}, 64'h0);
    check("tmo_strobe_drop", {63'h0, ren_at_err}, 64'h0);
    req_ren = '0; ram_busy = 1'b0;
    step();
    check("tmo_err_pulse", {62'h0, req_err}, 64'h0);
    step();

    // Reset mid-access; rr_ptr is 1 beforehand, so port0 winning afterwards shows it was cleared.
    req_ren = 2'b11; ram_busy = 1'b1;
    step(); step();
    check("mid_in_issue", {63'h0, ram_ren}, 64'h1);
    rst = 1'b1; req_ren = '0;
    step();
    check("mid_rst_outputs", {ram_ren, ram_wen, ram_addr, ram_wdata[29:0]}, 64'h0);
    check("mid_rst_resp", {req_rdata[61:0], req_ready}, 64'h0);
    check("mid_rst_err", {62'h0, req_err}, 64'h0);
    rst = 1'b0; ram_busy = 1'b0;
    step();
    check("mid_post_idle", {60'h0, req_ready, req_err}, 64'h0);
    req_ren = 2'b11;
    step();
    check("mid_first_grant", {32'h0, ram_addr}, {32'h0, A0});
    req_ren = '0; ram_rdata = 32'h5555_AAAA;
    step();
    check("mid_ready", {62'h0, req_ready}, 64'h1);
    step();

    // Request withdrawn during ISSUE still completes once.
    req_ren = 2'b01; ram_busy = 1'b1;
    step();
    check("wd_issue", {63'h0, ram_ren}, 64'h1);
    req_ren = '0;
    step();
    ram_busy = 1'b0; ram_rdata = 32'h0BAD_F00D;
    step();
    check("wd_ready", {62'h0, req_ready}, 64'h1);
    check("wd_rdata", req_rdata, {32'h0, 32'h0BAD_F00D});
    ready_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (req_ready != 2'b00) ready_cnt++;
    end
    check("wd_single_pulse", 64'(ready_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
